pipe_scheduler: RTL



---
 rtl/flappy_pkg.sv | 33 +++
 rtl/mod5_counter.sv | 19 +
 rtl/pipe_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and index arithmetic for the pipe scheduler.
package flappy_pkg;

    localparam int SCREEN_W     = 640;
    localparam int PIPE_W       = 40;
    localparam int PIPE_SPACING = 128;
    localparam int SCROLL_STEP  = 2;
    localparam int NUM_SLOTS    = 5;

    // Leading pipe starts fully off the right edge of the screen.
    localparam logic [9:0] X_INIT = 10'(SCREEN_W + PIPE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // (a + b) mod NUM_SLOTS; any out-of-range operand collapses the result to 0.
    function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        logic [2:0] r;
        s = {1'b0, a} + {1'b0, b};
        if (a >= 3'(NUM_SLOTS) || b >= 3'(NUM_SLOTS))
            r = 3'd0;
        else if (s >= 4'(NUM_SLOTS))
            r = 3'(s - 4'(NUM_SLOTS));
        else
            r = s[2:0];
        return r;
    endfunction

endpackage

// File: rtl/mod5_counter.sv
// Mod-5 counter: counts 0..4 when enabled, wraps 4->0, self-heals from 5..7.
module mod5_counter
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] q
);

    // Illegal values are cleared regardless of enable so a glitch cannot stick.
    always_ff @(posedge clk) begin
        if (rst || q >= 3'(NUM_SLOTS))
            q <= 3'd0;
        else if (en)
            q <= (q == 3'(NUM_SLOTS - 1)) ? 3'd0 : q + 3'd1;
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe field scheduler: scrolls the leading pipe, recycles it off the left
// edge, rotates the height-table index and keeps the passed-pipe score.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold, ticks ignored
//   RUN   | pipes scroll one step per tick; collide ends the game
//   OVER  | everything frozen; start reloads and returns to IDLE
module pipe_scheduler
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       collide,
    output logic [2:0] rom_index,
    output logic [9:0] x_right,
    output logic       pipe_passed,
    output logic [7:0] score,
    output logic       running,
    output logic       game_over
);

    state_t     state;
    logic [2:0] seed;
    logic [2:0] idx_base;
    logic [2:0] idx_off;
    logic       reload;
    logic       recycle;
    logic       off_clr;

    // rom_index = seed captured at reload plus the recycles since then, mod 5.
    // Reload snapshots the seed into idx_base and clears the offset counter.
    assign reload  = start && (state == IDLE || state == OVER);
    assign recycle = (state == RUN) && !collide && tick && (x_right <= 10'(SCROLL_STEP));
    assign off_clr = rst || reload;

    assign rom_index = add_mod5(idx_base, idx_off);

    mod5_counter u_seed (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (seed)
    );

    mod5_counter u_index_off (
        .clk (clk),
        .rst (off_clr),
        .en  (recycle),
        .q   (idx_off)
    );

    // Game FSM with registered outputs; collide beats tick in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_right     <= X_INIT;
            pipe_passed <= 1'b0;
            score       <= 8'd0;
            running     <= 1'b0;
            game_over   <= 1'b0;
            idx_base    <= 3'd0;
        end else begin
            pipe_passed <= recycle;
            if (idx_base >= 3'(NUM_SLOTS))
                idx_base <= 3'd0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                        x_right   <= X_INIT;
                        score     <= 8'd0;
                        idx_base  <= seed;
                    end
                end
                RUN: begin
                    if (collide) begin
                        state     <= OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                    end else if (tick) begin
                        if (x_right > 10'(SCROLL_STEP)) begin
                            x_right <= x_right - 10'(SCROLL_STEP);
                        end else begin
                            // x_right <= SCROLL_STEP here, so the sum stays far below 1024.
                            x_right <= x_right + 10'(PIPE_SPACING - SCROLL_STEP);
                            score   <= (score == 8'hFF) ? score : score + 8'd1;
                        end
                    end
                end
                OVER: begin
                    if (start) begin
                        state     <= IDLE;
                        running   <= 1'b0;
                        game_over <= 1'b0;
                        x_right   <= X_INIT;
                        score     <= 8'd0;
                        idx_base  <= seed;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
